// File: rtl/expander_pin_sequencer.sv
// Command sequencer feeding i2c_operator: queues bit writes, delays and apply-barriers,
// and holds the 29-bit expander pin shadow that drives i2c_operator's pin inputs.
module expander_pin_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic        err_clear,
  input  logic        busyI2C,
  output logic [11:0] CS,
  output logic [5:0]  SH_R,
  output logic [5:0]  EN,
  output logic        MUX,
  output logic        RS,
  output logic [2:0]  TESTIO,
  output logic        seq_idle,
  output logic        err_bad_index,
  output logic        err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ($clog2(BUSY_TIMEOUT) > 16) ? $clog2(BUSY_TIMEOUT) : 16;
  localparam int SH_W  = 29;

  localparam logic [1:0]       OP_WRITE_BIT    = 2'd0;
  localparam logic [1:0]       OP_CLEAR_ALL    = 2'd1;
  localparam logic [1:0]       OP_WAIT_APPLIED = 2'd2;
  localparam logic [1:0]       OP_DELAY        = 2'd3;
  localparam logic [PTR_W:0]   FULL_COUNT      = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ZERO_COUNT      = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE         = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE       = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO        = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [4:0]       MAX_INDEX       = 5'd28;

  typedef enum logic [1:0] {S_FETCH, S_DELAY, S_GUARD, S_WAIT} state_t;

  state_t              state_r, state_next_s;
  logic [17:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [SH_W-1:0]     shadow_r, shadow_next_s;
  logic                err_bad_index_r, err_timeout_r;
  logic                full_s, empty_s, push_s, pop_s;
  logic                bad_evt_s, timeout_evt_s;
  logic [1:0]          head_op_s;
  logic [15:0]         head_arg_s;
  logic [4:0]          head_idx_s;
  logic [SH_W-1:0]     bit_mask_s;

  assign full_s     = (count_r == FULL_COUNT);
  assign empty_s    = (count_r == ZERO_COUNT);
  assign push_s     = cmd_valid && !full_s;
  assign head_op_s  = fifo_mem_r[rd_ptr_r][17:16];
  assign head_arg_s = fifo_mem_r[rd_ptr_r][15:0];
  assign head_idx_s = head_arg_s[4:0];
  assign bit_mask_s = SH_W'(1) << head_idx_s;

  // Command queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= ZERO_COUNT;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_arg};
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and pop decision
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          case (head_op_s)
            OP_DELAY: begin
              if (head_arg_s != 16'd0) state_next_s = S_DELAY;
              else                     state_next_s = S_FETCH;
            end
            OP_WAIT_APPLIED: state_next_s = S_GUARD;
            default:         state_next_s = S_FETCH;
          endcase
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DELAY: begin
        if (cnt_r == CNT_ZERO) state_next_s = S_FETCH;
        else                   state_next_s = S_DELAY;
      end
      S_GUARD: state_next_s = S_WAIT;
      S_WAIT: begin
        if (!busyI2C)                   state_next_s = S_FETCH;
        else if (cnt_r == TIMEOUT_LAST) state_next_s = S_FETCH;
        else                            state_next_s = S_WAIT;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // FSM outputs: idle status and error events
  always_comb begin
    seq_idle      = empty_s && (state_r == S_FETCH);
    bad_evt_s     = 1'b0;
    timeout_evt_s = 1'b0;
    if (pop_s && (head_op_s == OP_WRITE_BIT) && (head_idx_s > MAX_INDEX)) begin
      bad_evt_s = 1'b1;
    end else begin
      bad_evt_s = 1'b0;
    end
    if ((state_r == S_WAIT) && busyI2C && (cnt_r == TIMEOUT_LAST)) begin
      timeout_evt_s = 1'b1;
    end else begin
      timeout_evt_s = 1'b0;
    end
  end

  // Next shadow and counter values; DELAY N loads N-1 so the next pop lands N+1 cycles later
  always_comb begin
    shadow_next_s = shadow_r;
    cnt_next_s    = cnt_r;
    if (pop_s) begin
      case (head_op_s)
        OP_WRITE_BIT: begin
          if (head_idx_s <= MAX_INDEX) begin
            if (head_arg_s[8]) shadow_next_s = shadow_r | bit_mask_s;
            else               shadow_next_s = shadow_r & ~bit_mask_s;
          end else begin
            shadow_next_s = shadow_r;
          end
        end
        OP_CLEAR_ALL:    shadow_next_s = SH_W'(0);
        OP_WAIT_APPLIED: cnt_next_s    = CNT_ZERO;
        OP_DELAY: begin
          if (head_arg_s != 16'd0) cnt_next_s = CNT_W'(head_arg_s) - CNT_ONE;
          else                     cnt_next_s = CNT_ZERO;
        end
        default: shadow_next_s = shadow_r;
      endcase
    end else if ((state_r == S_DELAY) && (cnt_r != CNT_ZERO)) begin
      cnt_next_s = cnt_r - CNT_ONE;
    end else if ((state_r == S_WAIT) && busyI2C && (cnt_r != TIMEOUT_LAST)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Shadow, counter and sticky error registers; a same-cycle error event beats err_clear
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r        <= SH_W'(0);
      cnt_r           <= CNT_ZERO;
      err_bad_index_r <= 1'b0;
      err_timeout_r   <= 1'b0;
    end else begin
      shadow_r        <= shadow_next_s;
      cnt_r           <= cnt_next_s;
      err_bad_index_r <= bad_evt_s | (err_bad_index_r & ~err_clear);
      err_timeout_r   <= timeout_evt_s | (err_timeout_r & ~err_clear);
    end
  end

  assign cmd_ready     = !full_s;
  assign CS            = shadow_r[11:0];
  assign SH_R          = shadow_r[17:12];
  assign EN            = shadow_r[23:18];
  assign MUX           = shadow_r[24];
  assign RS            = shadow_r[25];
  assign TESTIO        = shadow_r[28:26];
  assign err_bad_index = err_bad_index_r;
  assign err_timeout   = err_timeout_r;

endmodule
